instr_encode_loader: RTL and testbench

- Inverse of the instruction decode path: takes MIPS instruction fields (R/I/J format) over a valid/ready stream, packs them into 32-bit instruction words, and writes them sequentially into instruction memory.
- Used as the program loader in front of the single-cycle CPU's instruction memory for benches and bring-up.
- A start command fixes the base address and word count. The block then streams encoded words out one per cycle, using a one-entry output register with backpressure, and signals done.

---
 rtl/instr_encode_loader_pkg.sv | 42 ++++
 rtl/instr_encode_loader_if.sv | 30 +++
 rtl/instr_encode_loader_instr_pack.sv | 37 +++
 rtl/instr_encode_loader.sv | 95 +++++++++
 tb/tb_instr_encode_loader.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_encode_loader_pkg.sv
// rtl/instr_encode_loader_pkg.sv - shared formats, state codes and field positions for the loader
package instr_encode_loader_pkg;

   localparam logic [1:0] FMT_R   = 2'd0;
   localparam logic [1:0] FMT_I   = 2'd1;
   localparam logic [1:0] FMT_J   = 2'd2;
   localparam logic [1:0] FMT_ILL = 2'd3;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam int OP_MSB    = 31;
   localparam int OP_LSB    = 26;
   localparam int RS_MSB    = 25;
   localparam int RS_LSB    = 21;
   localparam int RT_MSB    = 20;
   localparam int RT_LSB    = 16;
   localparam int RD_MSB    = 15;
   localparam int RD_LSB    = 11;
   localparam int SHAMT_MSB = 10;
   localparam int SHAMT_LSB = 6;
   localparam int FUNCT_MSB = 5;
   localparam int FUNCT_LSB = 0;
   localparam int IMM_MSB   = 15;
   localparam int IMM_LSB   = 0;
   localparam int ADDR_MSB  = 25;
   localparam int ADDR_LSB  = 0;

   typedef struct packed {
      logic [1:0]  fmt;
      logic [5:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [5:0]  funct;
      logic [15:0] imm;
      logic [25:0] addr;
   } instr_fields_t;

endpackage

// File: rtl/instr_encode_loader_if.sv
// rtl/instr_encode_loader_if.sv - field input stream and instruction-memory write bus
interface instr_encode_loader_if #(
   parameter int ADDR_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        fmt;
   logic [5:0]        op;
   logic [4:0]        rs;
   logic [4:0]        rt;
   logic [4:0]        rd;
   logic [4:0]        shamt;
   logic [5:0]        funct;
   logic [15:0]       imm;
   logic [25:0]       addr;
   logic              mem_we;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;

   modport master (
      input  in_valid, fmt, op, rs, rt, rd, shamt, funct, imm, addr, mem_ready,
      output in_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output in_valid, fmt, op, rs, rt, rd, shamt, funct, imm, addr, mem_ready,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/instr_encode_loader_instr_pack.sv
// rtl/instr_encode_loader_instr_pack.sv - packs R/I/J fields into a 32-bit MIPS word
module instr_encode_loader_instr_pack
   import instr_encode_loader_pkg::*;
(
   input  instr_fields_t fields,
   output logic [31:0]   word,
   output logic          illegal
);

   // Illegal format encodes as an all-zero word (sll $0,$0,0, the canonical nop).
   always_comb begin
      word    = '0;
      illegal = 1'b0;
      case (fields.fmt)
         FMT_R: begin
            word[OP_MSB:OP_LSB]       = fields.op;
            word[RS_MSB:RS_LSB]       = fields.rs;
            word[RT_MSB:RT_LSB]       = fields.rt;
            word[RD_MSB:RD_LSB]       = fields.rd;
            word[SHAMT_MSB:SHAMT_LSB] = fields.shamt;
            word[FUNCT_MSB:FUNCT_LSB] = fields.funct;
         end
         FMT_I: begin
            word[OP_MSB:OP_LSB]   = fields.op;
            word[RS_MSB:RS_LSB]   = fields.rs;
            word[RT_MSB:RT_LSB]   = fields.rt;
            word[IMM_MSB:IMM_LSB] = fields.imm;
         end
         FMT_J: begin
            word[OP_MSB:OP_LSB]     = fields.op;
            word[ADDR_MSB:ADDR_LSB] = fields.addr;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encode_loader.sv
// rtl/instr_encode_loader.sv - streams encoded instructions into instruction memory
module instr_encode_loader
   import instr_encode_loader_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    base_addr,
   input  logic [CNT_W-1:0]     length,
   output logic                 busy,
   output logic                 done,
   output logic                 fmt_err,
   instr_encode_loader_if.master bus
);

   logic [1:0]       state;
   logic [CNT_W-1:0] accept_cnt;
   logic [CNT_W-1:0] write_cnt;
   instr_fields_t    fields;
   logic [31:0]      packed_word;
   logic             illegal;
   logic             accept;
   logic             handshake;

   always_comb begin
      fields       = '0;
      fields.fmt   = bus.fmt;
      fields.op    = bus.op;
      fields.rs    = bus.rs;
      fields.rt    = bus.rt;
      fields.rd    = bus.rd;
      fields.shamt = bus.shamt;
      fields.funct = bus.funct;
      fields.imm   = bus.imm;
      fields.addr  = bus.addr;
   end

   instr_encode_loader_instr_pack u_pack (
      .fields  (fields),
      .word    (packed_word),
      .illegal (illegal)
   );

   // The output register may reload in the same cycle it is drained.
   assign bus.in_ready = (state == LOAD) && (accept_cnt != '0) && (!bus.mem_we || bus.mem_ready);
   assign accept       = bus.in_valid && bus.in_ready;
   assign handshake    = bus.mem_we && bus.mem_ready;
   assign busy         = (state != IDLE);
   assign done         = (state == DONE);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= IDLE;
         accept_cnt    <= '0;
         write_cnt     <= '0;
         fmt_err       <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  bus.mem_addr <= base_addr & ~ADDR_W'(3);
                  accept_cnt   <= length;
                  write_cnt    <= length;
                  fmt_err      <= 1'b0;
                  state        <= (length == '0) ? DONE : LOAD;
               end
            end
            LOAD: begin
               if (accept) begin
                  bus.mem_wdata <= packed_word;
                  bus.mem_we    <= 1'b1;
                  accept_cnt    <= accept_cnt - 1'b1;
                  if (illegal) fmt_err <= 1'b1;
               end else if (handshake) begin
                  bus.mem_we <= 1'b0;
               end
               if (handshake) begin
                  bus.mem_addr <= bus.mem_addr + ADDR_W'(4);
                  write_cnt    <= write_cnt - 1'b1;
                  if (write_cnt == CNT_W'(1)) state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encode_loader.sv
// tb/tb_instr_encode_loader.sv - scoreboard bench for the instruction encode loader
module tb_instr_encode_loader;
   import instr_encode_loader_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [31:0] base_addr;
   logic [15:0] length;
   logic        busy, done, fmt_err;

   instr_encode_loader_if #(.ADDR_W(32)) ifc ();

   instr_encode_loader #(.ADDR_W(32), .CNT_W(16)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .busy      (busy),
      .done      (done),
      .fmt_err   (fmt_err),
      .bus       (ifc.master)
   );

   always #5 clk = ~clk;

   int          checks_total  = 0;
   int          checks_passed = 0;
   int          cyc           = 0;
   int          done_cnt      = 0;
   int          last_hs_cyc   = 0;
   int          last_done_cyc = 0;
   logic [63:0] exp_q[$];
   int          wr_cycles[$];
   logic [31:0] exp_addr;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else checks_passed++;
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every write handshake must match the oldest expected {addr,data}.
   always @(negedge clk) begin
      if (reset_n && ifc.mem_we && ifc.mem_ready) begin
         logic [63:0] e;
         last_hs_cyc = cyc;
         wr_cycles.push_back(cyc);
         if (exp_q.size() == 0) begin
            check("unexpected_write", {ifc.mem_addr, ifc.mem_wdata}, 64'hx);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", {32'h0, ifc.mem_addr}, {32'h0, e[63:32]});
            check("wr_data", {32'h0, ifc.mem_wdata}, {32'h0, e[31:0]});
         end
      end
      if (reset_n && done) begin
         done_cnt++;
         last_done_cyc = cyc;
      end
   end

   function automatic instr_fields_t mk_r(input logic [5:0] op, input logic [4:0] rs, rt, rd, sh,
                                          input logic [5:0] fn);
      instr_fields_t f = '1;
      f.fmt = FMT_R; f.op = op; f.rs = rs; f.rt = rt; f.rd = rd; f.shamt = sh; f.funct = fn;
      return f;
   endfunction

   function automatic instr_fields_t mk_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
      instr_fields_t f = '1;
      f.fmt = FMT_I; f.op = op; f.rs = rs; f.rt = rt; f.imm = imm;
      return f;
   endfunction

   function automatic instr_fields_t mk_j(input logic [5:0] op, input logic [25:0] a);
      instr_fields_t f = '1;
      f.fmt = FMT_J; f.op = op; f.addr = a;
      return f;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input instr_fields_t f);
      ifc.in_valid = 1'b1;
      ifc.fmt = f.fmt; ifc.op = f.op; ifc.rs = f.rs; ifc.rt = f.rt; ifc.rd = f.rd;
      ifc.shamt = f.shamt; ifc.funct = f.funct; ifc.imm = f.imm; ifc.addr = f.addr;
   endtask

   task automatic send(input instr_fields_t f, input logic [31:0] exp_word);
      logic ok;
      int   n = 0;
      drive(f);
      exp_q.push_back({exp_addr, exp_word});
      exp_addr = exp_addr + 32'd4;
      do begin
         @(negedge clk);
         ok = ifc.in_ready;
         tick();
         n++;
      end while (!ok && n < 40);
      if (!ok) check("accept_timeout", 0, 1);
   endtask

   task automatic do_start(input logic [31:0] base, input logic [15:0] len);
      start = 1'b1; base_addr = base; length = len;
      exp_addr = base & ~32'd3;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done();
      int d0 = done_cnt;
      int n  = 0;
      while (done_cnt == d0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (done_cnt == d0) check("done_timeout", 0, 1);
      tick();
   endtask

   initial begin
      int d0;
      reset_n = 1'b0; start = 1'b0; base_addr = '0; length = '0;
      ifc.in_valid = 1'b0; ifc.mem_ready = 1'b1; drive('0); ifc.in_valid = 1'b0;
      exp_addr = '0;
      repeat (3) tick();
      @(negedge clk);
      check("rst_in_ready", ifc.in_ready, 0);
      check("rst_mem_we", ifc.mem_we, 0);
      check("rst_busy_done_err", {busy, done, fmt_err}, 0);
      check("rst_addr_data", {ifc.mem_addr, ifc.mem_wdata}, 0);
      tick();
      reset_n = 1'b1;
      tick();

      // Single I-type with latency and done timing.
      do_start(32'h100, 16'd1);
      send(mk_i(6'd8, 5'd0, 5'd8, 16'd5), 32'h2008_0005);
      ifc.in_valid = 1'b0;
      @(negedge clk);
      check("latency_mem_we", ifc.mem_we, 1);
      check("single_busy", busy, 1);
      wait_done();
      check("done_after_hs", last_done_cyc, last_hs_cyc + 1);

      // Back-to-back mixed formats at full throughput.
      d0 = done_cnt;
      wr_cycles.delete();
      do_start(32'h0, 16'd3);
      send(mk_r(6'd0, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20), 32'h0109_5020);
      send(mk_j(6'd2, 26'h10), 32'h0800_0010);
      send(mk_j(6'd3, 26'h100), 32'h0C00_0100);
      ifc.in_valid = 1'b0;
      wait_done();
      repeat (3) tick();
      check("b2b_writes", wr_cycles.size(), 3);
      if (wr_cycles.size() == 3) begin
         check("b2b_gap0", wr_cycles[1] - wr_cycles[0], 1);
         check("b2b_gap1", wr_cycles[2] - wr_cycles[1], 1);
      end
      check("b2b_done_once", done_cnt - d0, 1);

      // Backpressure mid-stream.
      do_start(32'h200, 16'd4);
      send(mk_i(6'd8, 5'd1, 5'd2, 16'hFFFF), 32'h2022_FFFF);
      ifc.mem_ready = 1'b0;
      drive(mk_r(6'd0, 5'd0, 5'd3, 5'd4, 5'd5, 6'd0));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_mem_we", ifc.mem_we, 1);
         check("bp_addr", ifc.mem_addr, 32'h200);
         check("bp_wdata", ifc.mem_wdata, 32'h2022_FFFF);
         check("bp_in_ready", ifc.in_ready, 0);
         tick();
      end
      ifc.mem_ready = 1'b1;
      send(mk_r(6'd0, 5'd0, 5'd3, 5'd4, 5'd5, 6'd0), 32'h0003_2140);
      send(mk_j(6'd2, 26'h3FF_FFFF), 32'h0BFF_FFFF);
      send(mk_i(6'd8, 5'd1, 5'd2, 16'hFFFF), 32'h2022_FFFF);
      ifc.in_valid = 1'b0;
      wait_done();
      check("bp_drained", exp_q.size(), 0);

      // Illegal format, sticky error, zero-length start.
      do_start(32'h303, 16'd2);
      send('1, 32'h0000_0000);
      ifc.in_valid = 1'b0;
      @(negedge clk);
      check("ill_fmt_err", fmt_err, 1);
      tick();
      send(mk_i(6'h23, 5'd29, 5'd31, 16'd4), 32'h8FBF_0004);
      ifc.in_valid = 1'b0;
      wait_done();
      check("ill_sticky", fmt_err, 1);
      do_start(32'h40, 16'd0);
      @(negedge clk);
      check("len0_done", done, 1);
      check("len0_no_we", ifc.mem_we, 0);
      check("start_clears_err", fmt_err, 0);
      tick();
      @(negedge clk);
      check("len0_idle", {busy, done}, 0);
      tick();

      // Address wrap with unaligned base.
      do_start(32'hFFFF_FFFF, 16'd2);
      send(mk_j(6'd2, 26'h0), 32'h0800_0000);
      send(mk_r(6'd0, 5'd31, 5'd0, 5'd0, 5'd0, 6'd8), 32'h03E0_0008);
      ifc.in_valid = 1'b0;
      wait_done();

      // Start during LOAD is ignored; no accepts past the count.
      do_start(32'h400, 16'd2);
      send(mk_i(6'd8, 5'd0, 5'd8, 16'd5), 32'h2008_0005);
      ifc.in_valid = 1'b0;
      start = 1'b1; base_addr = 32'h800; length = 16'd5;
      tick();
      start = 1'b0;
      send(mk_j(6'd2, 26'h10), 32'h0800_0010);
      drive(mk_j(6'd3, 26'h100));
      @(negedge clk);
      check("cnt_exhausted_ready", ifc.in_ready, 0);
      check("cnt_exhausted_busy", busy, 1);
      wait_done();
      ifc.in_valid = 1'b0;

      // Reset while a write is pending.
      ifc.mem_ready = 1'b0;
      do_start(32'h500, 16'd3);
      send('1, 32'h0);
      ifc.in_valid = 1'b0;
      @(negedge clk);
      check("pre_rst_we", {ifc.mem_we, fmt_err}, 2'b11);
      reset_n = 1'b0;
      tick();
      @(negedge clk);
      check("mid_rst_we_ready", {ifc.mem_we, ifc.in_ready}, 0);
      check("mid_rst_flags", {busy, done, fmt_err}, 0);
      check("mid_rst_addr_data", {ifc.mem_addr, ifc.mem_wdata}, 0);
      exp_q.delete();
      reset_n = 1'b1;
      ifc.mem_ready = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      check("post_rst_idle", busy, 0);
      tick();
      do_start(32'h600, 16'd1);
      send(mk_i(6'd8, 5'd0, 5'd8, 16'd5), 32'h2008_0005);
      ifc.in_valid = 1'b0;
      wait_done();

      repeat (4) tick();
      check("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", checks_passed, checks_total);
      $fatal(1);
   end

endmodule
